ula_multiciclo: RTL
===================

ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 Parameter WIDTH, default 6, operand and result width in bits (legal range 2..32).
REQ-002 Parameter MUL_EN, default 1, enables the multi-cycle multiply; when 0, the MUL opcode behaves as ADD.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  high when an operation is presented on A, B, modo and op_sel.
REQ-006 in_ready  output  1  high when the block can accept an operation this cycle.
REQ-007 A, B  input  WIDTH each  operands.
REQ-008 modo  input  1  operation mode: 1 = logic, 0 = arithmetic.
REQ-009 op_sel  input  3  operation select.
REQ-010 out_valid  output  1  high while a result is presented.
REQ-011 out_ready  input  1  high when the consumer takes the presented result.
REQ-012 O  output  WIDTH  result.
REQ-013 carry_out, zero, overflow  output  1 each  flags for the presented result.
REQ-014 busy  output  1  high while a multiply is in progress.

Function
REQ-015 An operation is accepted in a cycle where in_valid and in_ready are both high; A, B, modo and op_sel are captured at acceptance, and later changes to them have no effect on that operation.
REQ-016 Logic mode (modo=1), decoded from op_sel:
- 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 NAND, 101 NOR, 110 XNOR, 111 pass A.
- carry_out=0 and overflow=0 for all logic operations.
REQ-017 Arithmetic mode (modo=0), decoded from op_sel:
- 000 A+B, 001 A-B, 010 A+1, 011 A-1.
- 100 A<<1, 101 A>>1 (logical shift).
- 110 MUL, 111 CMP, where CMP gives O={WIDTH-1 zeros, (A<B signed)}.
REQ-018 Arithmetic results are modulo 2^WIDTH.
REQ-019 carry_out per arithmetic operation:
- ADD/INC: carry out of bit WIDTH-1.
- SUB/DEC: borrow, i.e. 1 when A<B unsigned for SUB and when A==0 for DEC.
- SHL: A[WIDTH-1]; SHR: A[0].
- MUL: OR of product bits [2*WIDTH-1:WIDTH].
- CMP: 0.
REQ-020 overflow is the two's-complement signed overflow for ADD, SUB, INC and DEC, and 0 for all other operations.
REQ-021 zero is 1 exactly when O==0 for the presented result.
REQ-022 FSM states:
- IDLE: in_ready=1, out_valid=0.
- CALC: multiply in progress, busy=1, in_ready=0.
- DONE: out_valid=1.
REQ-023 Single-cycle operations: acceptance in IDLE moves the FSM to DONE; out_valid rises on the edge following acceptance (latency 1).
REQ-024 MUL: acceptance moves the FSM to CALC for exactly WIDTH cycles of shift-and-add, then to DONE; out_valid rises WIDTH+1 edges after acceptance.
REQ-025 In DONE, O and all flags SHALL hold stable while out_ready=0.
REQ-026 In DONE, in_ready equals out_ready, so back-to-back operations are supported.
REQ-027 In DONE with out_ready=1: if a new operation is accepted in the same cycle, the FSM goes to DONE or CALC per that operation; otherwise it goes to IDLE.
REQ-028 In IDLE, O and the flags retain the last presented values; in_valid=0 causes no state change.

Reset
REQ-029 While reset_n=0, regardless of clk:
- FSM is IDLE.
- out_valid, busy, O, carry_out, zero and overflow are 0.
- the multiply accumulator and counter are 0.
REQ-030 Reset asserted during CALC or DONE aborts the operation; its result is never presented.
REQ-031 in_ready is 1 on the first clock after reset_n rises.

Verification (WIDTH=6)
REQ-032 ADD, A=111111, B=000001, out_ready=1 -> next cycle O=000000, carry_out=1, zero=1, overflow=0.
REQ-033 ADD 011111+000001 -> O=100000, overflow=1, carry_out=0; SUB 000101-000111 -> O=111110, carry_out=1, overflow=0.
REQ-034 MUL 000111*001001 -> out_valid rises 7 edges after acceptance, busy=1 for 6 cycles, O=111111, carry_out=0; MUL 001000*001000 -> O=000000, carry_out=1, zero=1.
REQ-035 Logic NOT, modo=1, op_sel=011, A=000000 -> O=111111, zero=0; AND with A=000000, B=111111 -> O=000000, zero=1.
REQ-036 Hold out_ready=0 for 3 cycles after a result -> O and flags stable, in_ready=0; then raise out_ready with in_valid=1 -> new operation accepted in that cycle, next result the following cycle.
REQ-037 Assert reset_n=0 on the 3rd CALC cycle of a MUL -> all outputs 0 immediately, out_valid never rises for that MUL, in_ready=1 on the first clock after release.

Source files
------------

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: handshaked ALU with single-cycle logic/arithmetic operations
// and a WIDTH-cycle shift-and-add multiplier. Results and flags are registered
// and held until the consumer takes them.
module ula_multiciclo #(
  parameter int WIDTH  = 6,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             modo,
  input  logic [2:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam int MSB = WIDTH - 1;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   o_q, o_d;
  logic               c_q, c_d, z_q, z_d, v_q, v_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept, is_mul;
  logic [WIDTH:0]     add_ext, sub_ext, inc_ext, dec_ext, mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   alu_o;
  logic               alu_c, alu_v;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = !modo && (op_sel == 3'b110) && (MUL_EN != 0);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign O         = o_q;
  assign carry_out = c_q;
  assign zero      = z_q;
  assign overflow  = v_q;

  // Extended-width add/subtract; bit WIDTH is the carry or borrow.
  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} - {1'b0, B};
  assign inc_ext = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_ext = {1'b0, A} - {{WIDTH{1'b0}}, 1'b1};

  // One shift-and-add step: low half holds the remaining multiplier bits,
  // high half accumulates; the pair shifts right each step.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // Single-cycle result and carry/overflow flags from the live operands.
  always_comb begin
    alu_o = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    if (modo) begin
      case (op_sel)
        3'b000: alu_o = A & B;
        3'b001: alu_o = A | B;
        3'b010: alu_o = A ^ B;
        3'b011: alu_o = ~A;
        3'b100: alu_o = ~(A & B);
        3'b101: alu_o = ~(A | B);
        3'b110: alu_o = ~(A ^ B);
        3'b111: alu_o = A;
      endcase
    end else begin
      case (op_sel)
        3'b000, 3'b110: begin
          alu_o = add_ext[WIDTH-1:0];
          alu_c = add_ext[WIDTH];
          alu_v = (A[MSB] == B[MSB]) && (add_ext[MSB] != A[MSB]);
        end
        3'b001: begin
          alu_o = sub_ext[WIDTH-1:0];
          alu_c = sub_ext[WIDTH];
          alu_v = (A[MSB] != B[MSB]) && (sub_ext[MSB] != A[MSB]);
        end
        3'b010: begin
          alu_o = inc_ext[WIDTH-1:0];
          alu_c = inc_ext[WIDTH];
          alu_v = !A[MSB] && inc_ext[MSB];
        end
        3'b011: begin
          alu_o = dec_ext[WIDTH-1:0];
          alu_c = dec_ext[WIDTH];
          alu_v = A[MSB] && !dec_ext[MSB];
        end
        3'b100: begin
          alu_o = {A[WIDTH-2:0], 1'b0};
          alu_c = A[MSB];
        end
        3'b101: begin
          alu_o = {1'b0, A[WIDTH-1:1]};
          alu_c = A[0];
        end
        3'b111: alu_o[0] = $signed(A) < $signed(B);
      endcase
    end
  end

  // FSM, operand capture, multiply sequencing and result registers.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    c_d     = c_q;
    z_d     = z_q;
    v_d     = v_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CALC: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          o_d     = mul_next[WIDTH-1:0];
          c_d     = |mul_next[2*WIDTH-1:WIDTH];
          z_d     = ~|mul_next[WIDTH-1:0];
          v_d     = 1'b0;
        end
      end
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = S_CALC;
            prod_d  = {{WIDTH{1'b0}}, B};
            mcand_d = A;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            o_d     = alu_o;
            c_d     = alu_c;
            z_d     = ~|alu_o;
            v_d     = alu_v;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      c_q     <= c_d;
      z_q     <= z_d;
      v_q     <= v_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
